// File: rtl/series_job_scheduler_pkg.sv
// rtl/series_job_scheduler_pkg.sv - state encodings and clog2 helper shared by the scheduler files
package series_job_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADX = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/series_rr_pick.sv
// rtl/series_rr_pick.sv - combinational winner pick, search from i_ptr upward with wrap
module series_rr_pick
  import series_job_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic [ID_W-1:0] w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_any         = 1'b1;
        o_idx         = w_j;
        o_onehot[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/series_job_scheduler.sv
// rtl/series_job_scheduler.sv - arbitrates NREQ clients onto one series datapath and sequences its term steps
// RR_FAIR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module series_job_scheduler
  import series_job_scheduler_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int X_W   = 8,
  parameter int TERMS = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*X_W-1:0] x_in,
  output logic [NREQ-1:0]     gnt,
  output logic [X_W-1:0]      dp_x,
  output logic                dp_load_x,
  output logic                dp_load_t,
  output logic                dp_select_t,
  output logic                busy,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id
);

  localparam int CNT_W = clog2(TERMS) + 1;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_owner;
  logic [NREQ-1:0]  r_gnt;
  logic [X_W-1:0]   r_dp_x;
  logic [NREQ-1:0]  w_onehot;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_ptr;
  logic             w_any;
  logic             w_arb;

`ifdef RR_FAIR_EN
  logic [ID_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_arb) begin
      r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + ID_W'(1);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  series_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (w_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Arbitration happens only between jobs, so mid-job req changes are ignored.
  assign w_arb = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_any;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_any ? S_LOADX : S_IDLE;
      S_LOADX: w_next = S_ITER;
      S_ITER:  w_next = (r_cnt == CNT_W'(TERMS - 1)) ? S_DONE : S_ITER;
      S_DONE:  w_next = w_any ? S_LOADX : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_dp_x  <= '0;
    end else begin
      r_state <= w_next;
      r_gnt   <= w_arb ? w_onehot : '0;
      if (w_arb) begin
        r_owner <= w_idx;
        r_dp_x  <= x_in[w_idx*X_W +: X_W];
      end
      if (r_state == S_LOADX) begin
        r_cnt <= CNT_W'(1);
      end else if (r_state == S_ITER) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign gnt         = r_gnt;
  assign dp_x        = r_dp_x;
  assign dp_load_x   = (r_state == S_LOADX);
  assign dp_load_t   = (r_state == S_LOADX) || (r_state == S_ITER);
  assign dp_select_t = (r_state == S_LOADX);
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = (r_state == S_DONE);
  assign rsp_id      = (r_state == S_DONE) ? r_owner : '0;

endmodule

// File: tb/tb_series_job_scheduler.sv
// tb/tb_series_job_scheduler.sv - scoreboard bench for series_job_scheduler (NREQ=4, X_W=8, TERMS=4)
module tb_series_job_scheduler;

  localparam int NREQ  = 4;
  localparam int X_W   = 8;
  localparam int TERMS = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*X_W-1:0] x_in = '0;
  logic [NREQ-1:0]     gnt;
  logic [X_W-1:0]      dp_x;
  logic                dp_load_x, dp_load_t, dp_select_t, busy, rsp_valid;
  logic [ID_W-1:0]     rsp_id;

  series_job_scheduler #(
    .NREQ  (NREQ),
    .X_W   (X_W),
    .TERMS (TERMS),
    .ID_W  (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .x_in        (x_in),
    .gnt         (gnt),
    .dp_x        (dp_x),
    .dp_load_x   (dp_load_x),
    .dp_load_t   (dp_load_t),
    .dp_select_t (dp_select_t),
    .busy        (busy),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [7:0] v;
  } ev_t;

  ev_t gq[$];
  ev_t rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input int c, input logic [3:0] g, input logic [7:0] v);
    ev_t e;
    e.cyc = c; e.g = g; e.v = v;
    gq.push_back(e);
  endtask

  task automatic exp_rsp(input int c, input logic [1:0] id);
    ev_t e;
    e.cyc = c; e.g = '0; e.v = {6'd0, id};
    rq.push_back(e);
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, {gnt, dp_x, dp_load_x, dp_load_t, dp_select_t, busy, rsp_valid, rsp_id}, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT grants or responds.
  always @(negedge clk) begin
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      chk("gnt_missed", 32'(cyc), 32'(gq[0].cyc));
      void'(gq.pop_front());
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      chk("rsp_missed", 32'(cyc), 32'(rq[0].cyc));
      void'(rq.pop_front());
    end
    if (gnt != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        chk("gnt_cycle", 32'(cyc), 32'(gq[0].cyc));
        chk("gnt_value", 32'(gnt), 32'(gq[0].g));
        chk("gnt_dp_x", 32'(dp_x), 32'(gq[0].v));
        chk("gnt_load_x", 32'(dp_load_x), 32'd1);
        void'(gq.pop_front());
      end
    end
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF);
      end else begin
        chk("rsp_cycle", 32'(cyc), 32'(rq[0].cyc));
        chk("rsp_id", 32'(rsp_id), 32'(rq[0].v));
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    int c;
    logic [3:0] g;
    x_in = {8'h43, 8'h42, 8'h41, 8'h40};

    // Reset with all requesters pending
    req = 4'b1111;
    rst = 1'b1;
    tick();
    chk_quiet("reset_c0");
    tick();
    chk_quiet("reset_c1");
    rst = 1'b0;
    c = cyc;
    exp_gnt(c + 1, 4'b0001, 8'h40);
    exp_rsp(c + 5, 2'd0);
    tick();
    req = '0;
    repeat (6) tick();

    // Single job from requester 1 with per-cycle datapath control checks
    x_in[1*X_W +: X_W] = 8'h15;
    req = 4'b0010;
    c = cyc;
    exp_gnt(c + 1, 4'b0010, 8'h15);
    exp_rsp(c + 5, 2'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      req = '0;
      chk($sformatf("load_x_k%0d", k), 32'(dp_load_x), 32'(k == 1));
      chk($sformatf("load_t_k%0d", k), 32'(dp_load_t), 32'(k <= 4));
      chk($sformatf("sel_t_k%0d", k), 32'(dp_select_t), 32'(k == 1));
      chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= 5));
    end
    chk("dp_x_hold", 32'(dp_x), 32'h15);
    x_in[1*X_W +: X_W] = 8'h41;

    // All four requesters held high: five back-to-back jobs
    req = 4'b1111;
    c = cyc;
    for (int k = 0; k < 5; k++) begin
`ifdef RR_FAIR_EN
      g = 4'b0001 << (k % 4);
`else
      g = 4'b0001;
`endif
      exp_gnt(c + 1 + 5*k, g, 8'h40 + 8'((g == 4'b0010) ? 1 : (g == 4'b0100) ? 2 : (g == 4'b1000) ? 3 : 0));
      exp_rsp(c + 5 + 5*k, 2'((g == 4'b0010) ? 1 : (g == 4'b0100) ? 2 : (g == 4'b1000) ? 3 : 0));
    end
    repeat (21) tick();
    req = '0;
    repeat (6) tick();

    // Two upper requesters: index 2 wins
    req = 4'b1100;
    c = cyc;
    exp_gnt(c + 1, 4'b0100, 8'h42);
    exp_rsp(c + 5, 2'd2);
    tick();
    req = '0;
    repeat (6) tick();

    // Reset during the second ITER cycle aborts the job
    req = 4'b0100;
    c = cyc;
    exp_gnt(c + 1, 4'b0100, 8'h42);
    tick();
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_quiet("abort_quiet");
    rst = 1'b0;
    req = 4'b1010;
    c = cyc;
    exp_gnt(c + 1, 4'b0010, 8'h41);
    exp_rsp(c + 5, 2'd1);
    tick();
    req = '0;
    repeat (6) tick();

    // Request in DONE cycle is granted without an IDLE gap; short pulse mid-job is lost
    req = 4'b0001;
    c = cyc;
    exp_gnt(c + 1, 4'b0001, 8'h40);
    exp_rsp(c + 5, 2'd0);
    tick();
    req = '0;
    tick();
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    req = 4'b1000;
    exp_gnt(c + 6, 4'b1000, 8'h43);
    exp_rsp(c + 10, 2'd3);
    tick();
    chk("done_regrant_load_x", 32'(dp_load_x), 32'd1);
    req = '0;
    repeat (8) tick();

    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
